piece_bag_generator: RTL and testbench

- Consumes the random words produced by union_random_generator and converts them into Tetris piece IDs using a 7-bag scheme. Each bag of 7 consecutive pieces contains every piece exactly once.
- Buffers upcoming pieces in a small preview queue.
- Feeds the game controller's spawn logic and the next-piece display.

---
 rtl/piece_bag_generator.sv | 171 +++++++++++++++++
 tb/tb_piece_bag_generator.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/piece_bag_generator.sv
// piece_bag_generator
// Turns random words into Tetris piece IDs using a 7-bag scheme. Every run of
// seven consecutive draws since reset/clear holds each piece exactly once.
// Drawn pieces wait in an in-order preview queue whose head is piece_o.
// Piece IDs: 0=I 1=O 2=T 3=S 4=Z 5=J 6=L (7 is never produced).
module piece_bag_generator #(
    parameter int width_p       = 8,
    parameter int queue_depth_p = 3
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         clear_i,
    input  logic [width_p-1:0]           random_i,
    input  logic                         v_i,
    output logic                         yumi_o,
    output logic [2:0]                   piece_o,
    output logic                         v_o,
    input  logic                         yumi_i,
    output logic [queue_depth_p*3-1:0]   preview_o,
    output logic [queue_depth_p-1:0]     preview_v_o,
    output logic [2:0]                   bag_remaining_o
);

    // Bag state: set bit = piece still undrawn; remaining_r tracks popcount(mask_r).
    logic [6:0]               mask_r;
    logic [6:0]               mask_n;
    logic [2:0]               remaining_r;
    logic [2:0]               remaining_n;

    // Preview queue: slot 0 is the head; valid bits are thermometer-coded and
    // invalid slots are kept at zero so they read back as 0.
    logic [2:0]               slot_r     [queue_depth_p];
    logic [2:0]               slot_shift [queue_depth_p];
    logic [2:0]               slot_n     [queue_depth_p];
    logic [queue_depth_p-1:0] valid_r;
    logic [queue_depth_p-1:0] valid_shift;
    logic [queue_depth_p-1:0] valid_n;

    logic                     full;
    logic                     deq;
    logic                     enq;
    logic [width_p-1:0]       n_ext;
    logic [width_p-1:0]       k_full;
    logic [2:0]               sel_piece;
    logic [6:0]               mask_cleared;

    assign full  = valid_r[queue_depth_p-1];
    // A dequeue with nothing queued is ignored rather than underflowing.
    assign deq   = yumi_i & valid_r[0] & ~clear_i;
    assign enq   = yumi_o;

    // Accepting while full is only possible because the head leaves on the same edge.
    assign yumi_o = v_i & ~reset_i & ~clear_i & (~full | yumi_i);

    // k = random mod n, evaluated on the full random word width.
    assign n_ext  = width_p'(remaining_r);
    assign k_full = random_i % n_ext;

    // Pick the k-th set bit of the bag mask, counting upward from bit 0.
    always_comb begin
        logic [width_p-1:0] cnt;
        sel_piece = 3'd0;
        cnt       = '0;
        for (int b = 0; b < 7; b++) begin
            if (mask_r[b]) begin
                if (cnt == k_full) begin
                    sel_piece = 3'(b);
                end
                cnt = cnt + 1'b1;
            end
        end
    end

    // Remove the drawn piece from the bag and refill when the bag empties.
    always_comb begin
        mask_cleared = mask_r & ~(7'd1 << sel_piece);
        mask_n       = mask_r;
        remaining_n  = remaining_r;
        if (enq) begin
            if (mask_cleared == 7'd0) begin
                mask_n      = 7'h7F;
                remaining_n = 3'd7;
            end else begin
                mask_n      = mask_cleared;
                remaining_n = remaining_r - 3'd1;
            end
        end
    end

    // Queue next state: shift toward the head on dequeue, then append at the first free slot.
    always_comb begin
        logic placed;
        for (int i = 0; i < queue_depth_p; i++) begin
            slot_shift[i] = slot_r[i];
        end
        valid_shift = valid_r;
        if (deq) begin
            for (int i = 0; i < queue_depth_p - 1; i++) begin
                slot_shift[i]  = slot_r[i+1];
                valid_shift[i] = valid_r[i+1];
            end
            slot_shift[queue_depth_p-1]  = 3'd0;
            valid_shift[queue_depth_p-1] = 1'b0;
        end

        for (int i = 0; i < queue_depth_p; i++) begin
            slot_n[i] = slot_shift[i];
        end
        valid_n = valid_shift;
        placed  = 1'b0;
        if (enq) begin
            for (int i = 0; i < queue_depth_p; i++) begin
                if (!valid_shift[i] && !placed) begin
                    slot_n[i]  = sel_piece;
                    valid_n[i] = 1'b1;
                    placed     = 1'b1;
                end
            end
        end
    end

    // Bag and queue registers; clear has the same effect as reset.
    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            mask_r      <= 7'h7F;
            remaining_r <= 3'd7;
            valid_r     <= '0;
            for (int i = 0; i < queue_depth_p; i++) begin
                slot_r[i] <= 3'd0;
            end
        end else begin
            mask_r      <= mask_n;
            remaining_r <= remaining_n;
            valid_r     <= valid_n;
            for (int i = 0; i < queue_depth_p; i++) begin
                slot_r[i] <= slot_n[i];
            end
        end
    end

    // Present registered queue and bag state.
    always_comb begin
        for (int i = 0; i < queue_depth_p; i++) begin
            preview_o[3*i +: 3] = slot_r[i];
        end
    end

    assign piece_o         = slot_r[0];
    assign v_o             = valid_r[0];
    assign preview_v_o     = valid_r;
    assign bag_remaining_o = remaining_r;

    // Shadow bag tracker: within each 7-draw bag no ID repeats and ID 7 never appears.
    logic [7:0] seen_r;
    logic [7:0] seen_next;
    assign seen_next = seen_r | (8'd1 << sel_piece);

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            seen_r <= 8'd0;
        end else if (enq) begin
            assert (sel_piece != 3'd7 && !seen_r[sel_piece]);
            if (seen_next[6:0] == 7'h7F) begin
                seen_r <= 8'd0;
            end else begin
                seen_r <= seen_next;
            end
        end
    end

endmodule

// File: tb/tb_piece_bag_generator.sv
// Testbench for piece_bag_generator: directed scenarios plus a long random run,
// all checked against a list-based bag/queue model.
module tb_piece_bag_generator;

    localparam int W = 8;
    localparam int D = 3;

    logic              clk_i = 1'b0;
    logic              reset_i = 1'b1;
    logic              clear_i = 1'b0;
    logic [W-1:0]      random_i = '0;
    logic              v_i = 1'b0;
    logic              yumi_o;
    logic [2:0]        piece_o;
    logic              v_o;
    logic              yumi_i = 1'b0;
    logic [D*3-1:0]    preview_o;
    logic [D-1:0]      preview_v_o;
    logic [2:0]        bag_remaining_o;

    piece_bag_generator #(.width_p(W), .queue_depth_p(D)) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .clear_i         (clear_i),
        .random_i        (random_i),
        .v_i             (v_i),
        .yumi_o          (yumi_o),
        .piece_o         (piece_o),
        .v_o             (v_o),
        .yumi_i          (yumi_i),
        .preview_o       (preview_o),
        .preview_v_o     (preview_v_o),
        .bag_remaining_o (bag_remaining_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int passes = 0;

    // Model: bag is the sorted list of undrawn pieces, mq the queued pieces in order.
    int   bag[$];
    int   mq[$];
    logic exp_yumi;
    logic got_yumi;

    function automatic void bag_refill();
        bag.delete();
        for (int p = 0; p < 7; p++) bag.push_back(p);
    endfunction

    function automatic logic [D*3-1:0] exp_preview();
        logic [D*3-1:0] v = '0;
        for (int i = 0; i < D; i++)
            if (i < mq.size()) v[3*i +: 3] = 3'(mq[i]);
        return v;
    endfunction

    function automatic logic [D-1:0] exp_preview_v();
        logic [D-1:0] v = '0;
        for (int i = 0; i < D; i++)
            if (i < mq.size()) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [2:0] exp_piece();
        return (mq.size() > 0) ? 3'(mq[0]) : 3'd0;
    endfunction

    // One clock: drive inputs, sample yumi_o mid-cycle, advance the model, land 1 after posedge.
    task automatic tick(input logic v, input logic [W-1:0] r, input logic y,
                        input logic clr, input logic rst);
        int k;
        v_i = v; random_i = r; yumi_i = y; clear_i = clr; reset_i = rst;
        @(negedge clk_i);
        got_yumi = yumi_o;
        exp_yumi = v && !clr && !rst && (mq.size() < D || y);
        if (rst || clr) begin
            mq.delete();
            bag_refill();
        end else begin
            if (y && mq.size() > 0) void'(mq.pop_front());
            if (exp_yumi) begin
                k = int'(r) % bag.size();
                mq.push_back(bag[k]);
                bag.delete(k);
                if (bag.size() == 0) bag_refill();
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        tick(1'b1, '1, 1'b0, 1'b0, 1'b1);
        tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset_i = 1'b1; v_i = 1'b1; yumi_i = 1'b1; random_i = 8'h5A;
        @(negedge clk_i);
        checks++;
        if (yumi_o !== 1'b0) $display("FAIL reset_yumi got=%b want=0", yumi_o);
        else passes++;
        tick(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1);
        checks++;
        if (v_o !== 1'b0) $display("FAIL reset_v got=%b want=0", v_o); else passes++;
        checks++;
        if (preview_v_o !== '0) $display("FAIL reset_preview_v got=%b want=0", preview_v_o); else passes++;
        checks++;
        if (piece_o !== 3'd0 || preview_o !== '0)
            $display("FAIL reset_data got piece=%0d preview=%h want 0/0", piece_o, preview_o);
        else passes++;
        checks++;
        if (bag_remaining_o !== 3'd7) $display("FAIL reset_bag got=%0d want=7", bag_remaining_o); else passes++;
    endtask

    task automatic test_zero_sequence();
        int want;
        do_reset();
        for (int c = 0; c < 18; c++) begin
            tick(1'b1, 8'h00, mq.size() > 0, 1'b0, 1'b0);
            checks++;
            if (v_o !== 1'b1 || piece_o !== exp_piece() || bag_remaining_o !== 3'(bag.size()))
                $display("FAIL zero_seq cycle=%0d got v=%b piece=%0d bag=%0d want v=1 piece=%0d bag=%0d",
                         c, v_o, piece_o, bag_remaining_o, exp_piece(), bag.size());
            else passes++;
            // A steady one-in one-out flow of zeros yields 0,1,...,6 and the bag counts down 6..1,7.
            want = c % 7;
            checks++;
            if (piece_o !== 3'(want)) $display("FAIL zero_seq_const cycle=%0d got=%0d want=%0d", c, piece_o, want);
            else passes++;
        end
    endtask

    task automatic test_ff_sequence();
        int first_bag[7] = '{3, 4, 0, 6, 1, 5, 2};
        int taken[$];
        do_reset();
        for (int c = 0; c < 15; c++) begin
            if (v_o) taken.push_back(int'(piece_o));
            tick(1'b1, 8'hFF, mq.size() > 0, 1'b0, 1'b0);
            checks++;
            if (piece_o !== exp_piece() || bag_remaining_o !== 3'(bag.size()))
                $display("FAIL ff_seq cycle=%0d got piece=%0d bag=%0d want piece=%0d bag=%0d",
                         c, piece_o, bag_remaining_o, exp_piece(), bag.size());
            else passes++;
        end
        for (int i = 0; i < 14; i++) begin
            checks++;
            if (taken[i] != first_bag[i % 7])
                $display("FAIL ff_bag_order idx=%0d got=%0d want=%0d", i, taken[i], first_bag[i % 7]);
            else passes++;
        end
    endtask

    task automatic test_fill_and_full_dequeue();
        int accepts = 0;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            tick(1'b1, W'($urandom), 1'b0, 1'b0, 1'b0);
            if (got_yumi) accepts++;
        end
        checks++;
        if (accepts != 3) $display("FAIL fill_accepts got=%0d want=3", accepts); else passes++;
        checks++;
        if (preview_v_o !== 3'b111 || preview_o !== exp_preview())
            $display("FAIL fill_preview got v=%b data=%h want v=111 data=%h", preview_v_o, preview_o, exp_preview());
        else passes++;
        tick(1'b1, W'($urandom), 1'b1, 1'b0, 1'b0);
        checks++;
        if (got_yumi !== 1'b1) $display("FAIL full_deq_yumi got=%b want=1", got_yumi); else passes++;
        checks++;
        if (preview_v_o !== 3'b111 || preview_o !== exp_preview())
            $display("FAIL full_deq_preview got v=%b data=%h want v=111 data=%h", preview_v_o, preview_o, exp_preview());
        else passes++;
        // Illegal dequeue on an empty queue must change nothing.
        do_reset();
        tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (v_o !== 1'b0 || preview_v_o !== '0 || bag_remaining_o !== 3'd7)
            $display("FAIL empty_deq got v=%b pv=%b bag=%0d want 0/0/7", v_o, preview_v_o, bag_remaining_o);
        else passes++;
    endtask

    task automatic test_clear();
        do_reset();
        for (int c = 0; c < 3; c++) tick(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bag_remaining_o !== 3'd4 || preview_v_o !== 3'b111)
            $display("FAIL clear_setup got bag=%0d pv=%b want 4/111", bag_remaining_o, preview_v_o);
        else passes++;
        tick(1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
        checks++;
        if (got_yumi !== 1'b0) $display("FAIL clear_yumi got=%b want=0", got_yumi); else passes++;
        checks++;
        if (v_o !== 1'b0 || preview_v_o !== '0 || bag_remaining_o !== 3'd7)
            $display("FAIL clear_state got v=%b pv=%b bag=%0d want 0/0/7", v_o, preview_v_o, bag_remaining_o);
        else passes++;
        tick(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (v_o !== 1'b1 || piece_o !== 3'd0)
            $display("FAIL clear_first got v=%b piece=%0d want 1/0", v_o, piece_o);
        else passes++;
    endtask

    task automatic test_random();
        int win[$];
        int pieces = 0;
        logic [7:0] seen;
        do_reset();
        for (int c = 0; c < 24000 && pieces < 10000; c++) begin
            logic v, y, clr;
            v   = ($urandom_range(0, 9) < 7);
            y   = ($urandom_range(0, 9) < 6);
            clr = ($urandom_range(0, 999) == 0);
            if (y && v_o && !clr) begin
                win.push_back(int'(piece_o));
                pieces++;
            end
            if (clr) win.delete();
            tick(v, W'($urandom), y, clr, 1'b0);
            checks++;
            if (got_yumi !== exp_yumi) $display("FAIL rnd_yumi cycle=%0d got=%b want=%b", c, got_yumi, exp_yumi);
            else passes++;
            checks++;
            if (v_o !== (mq.size() > 0) || piece_o !== exp_piece() || preview_o !== exp_preview() ||
                preview_v_o !== exp_preview_v() || bag_remaining_o !== 3'(bag.size()))
                $display("FAIL rnd_state cycle=%0d got v=%b piece=%0d pv=%b pd=%h bag=%0d want v=%b piece=%0d pv=%b pd=%h bag=%0d",
                         c, v_o, piece_o, preview_v_o, preview_o, bag_remaining_o,
                         mq.size() > 0, exp_piece(), exp_preview_v(), exp_preview(), bag.size());
            else passes++;
            if (win.size() == 7) begin
                seen = '0;
                foreach (win[i]) seen[win[i]] = 1'b1;
                checks++;
                if (seen !== 8'h7F) $display("FAIL rnd_window cycle=%0d got mask=%h want=7f", c, seen);
                else passes++;
                win.delete();
            end
        end
        checks++;
        if (pieces < 10000) $display("FAIL rnd_piece_count got=%0d want>=10000", pieces);
        else passes++;
    endtask

    initial begin
        bag_refill();
        test_reset();
        test_zero_sequence();
        test_ff_sequence();
        test_fill_and_full_dequeue();
        test_clear();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
